// File: rtl/stack_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_seq_if
// Description : Request, response and data-memory bundle of the stack sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_seq_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_data, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  // Control unit plus data memory side.
  modport master (
    output req_valid, req_op, req_data, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface
`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module      : stack_seq
// Description : Empty-descending stack sequencer: push/pop/peek/load-SP with
//               memory strobes, response handshake and sticky ovf/udf flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_seq #(
  parameter logic [7:0] SP_TOP   = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'hAF
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  stack_seq_if.slave      bus,
  output logic [7:0]      sp,
  output logic            ovf,
  output logic            udf
);

  localparam logic [1:0] c_OP_PUSH = 2'b00;
  localparam logic [1:0] c_OP_POP  = 2'b01;
  localparam logic [1:0] c_OP_LOAD = 2'b10;
  localparam logic [1:0] c_OP_PEEK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [7:0] r_data;
  logic [7:0] r_sp;
  logic       r_ovf;
  logic       r_udf;
  logic [7:0] r_rsp_data;
  logic       r_rsp_err;

  logic w_accept;
  logic w_empty;
  logic w_full;
  logic w_is_read;

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_empty   = (r_sp == SP_TOP);
  assign w_full    = (r_sp <= SP_LIMIT);
  assign w_is_read = (bus.req_op == c_OP_POP) || (bus.req_op == c_OP_PEEK);

  assign sp           = r_sp;
  assign ovf          = r_ovf;
  assign udf          = r_udf;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes decode from state alone so reset removes them without waiting for an edge.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_op == c_OP_PUSH) begin
            w_next = S_WRITE;
          end else if (w_is_read) begin
            w_next = w_empty ? S_RESP : S_READ;
          end
        end
      end
      S_WRITE: begin
        if (!w_full) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = r_sp;
          bus.mem_wdata = r_data;
        end
        w_next = S_IDLE;
      end
      S_READ: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = r_sp + 8'd1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= c_OP_PUSH;
      r_data     <= 8'h00;
      r_sp       <= SP_TOP;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rsp_data <= 8'h00;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.req_op;
            r_data <= bus.req_data;
            if (bus.req_op == c_OP_LOAD) begin
              r_sp  <= bus.req_data;
              r_ovf <= 1'b0;
              r_udf <= 1'b0;
            end else if (w_is_read && w_empty) begin
              r_rsp_data <= 8'h00;
              r_rsp_err  <= 1'b1;
              r_udf      <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_sp <= r_sp - 8'd1;
          end
        end
        S_READ: begin
          if (r_op == c_OP_POP) begin
            r_sp <= r_sp + 8'd1;
          end
        end
        S_WAIT: begin
          r_rsp_data <= bus.mem_rdata;
          r_rsp_err  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_seq
// Description : Scoreboard bench for stack_seq with a behavioural stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_seq;
  localparam logic [7:0] SP_TOP   = 8'hFF;
  localparam logic [7:0] SP_LIMIT = 8'hAF;
  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_PEEK  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_seq_if bus ();
  logic [7:0] sp;
  logic       ovf;
  logic       udf;

  stack_seq #(.SP_TOP(SP_TOP), .SP_LIMIT(SP_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sp    (sp),
    .ovf   (ovf),
    .udf   (udf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int n_rsp = 0;
  int last_busy = 0;
  logic rand_rdy = 1'b1;

  // Reference model: stack contents by address plus pointer and flags.
  logic [7:0] refm [256];
  logic [7:0] m_sp;
  logic       m_ovf;
  logic       m_udf;
  logic [15:0] wrq[$];
  logic [7:0]  rdq[$];
  logic [8:0]  rspq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory: registered read, one-cycle latency.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every observed strobe/response is matched against the queues.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_we) begin
          if (wrq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=%0h/%0h required=none", bus.mem_addr, bus.mem_wdata);
          end else chk("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wrq.pop_front()));
        end
        if (bus.mem_re) begin
          if (rdq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read actual=%0h required=none", bus.mem_addr);
          end else chk("mem_read_addr", 32'(bus.mem_addr), 32'(rdq.pop_front()));
        end
        if (bus.rsp_valid && !prev_v) first_cyc = cyc;
        if (bus.rsp_valid && bus.rsp_ready) begin
          n_rsp++;
          if (rspq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_response actual=%0h/%0b required=none", bus.rsp_data, bus.rsp_err);
          end else chk("response", 32'({bus.rsp_data, bus.rsp_err}), 32'(rspq.pop_front()));
        end
        prev_v = bus.rsp_valid;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  task automatic model_reset();
    wrq.delete(); rdq.delete(); rspq.delete();
    m_sp = SP_TOP; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [7:0] d);
    int n;
    logic [7:0] a;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_op = o; bus.req_data = d;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    case (o)
      OP_PUSH: begin
        if (m_sp <= SP_LIMIT) m_ovf = 1'b1;
        else begin
          wrq.push_back({m_sp, d});
          refm[m_sp] = d;
          m_sp = m_sp - 8'd1;
        end
      end
      OP_LOAD: begin
        m_sp = d; m_ovf = 1'b0; m_udf = 1'b0;
      end
      default: begin
        if (m_sp == SP_TOP) begin
          m_udf = 1'b1;
          rspq.push_back({8'h00, 1'b1});
        end else begin
          a = m_sp + 8'd1;
          rdq.push_back(a);
          rspq.push_back({refm[a], 1'b0});
          if (o == OP_POP) m_sp = a;
        end
      end
    endcase
  endtask

  task automatic wait_idle();
    last_busy = 0;
    @(negedge clk);
    while (!bus.req_ready && last_busy < 300) begin last_busy++; @(negedge clk); end
    if (!bus.req_ready) chk("idle_timeout", 32'd0, 32'd1);
    chk("sp", 32'(sp), 32'(m_sp));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
  endtask

  task automatic op(input logic [1:0] o, input logic [7:0] d);
    do_op(o, d);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_before;
    int r;
    logic [7:0] v;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 8'h00;
    for (int i = 0; i < 256; i++) refm[i] = 8'h00;
    do_reset();

    chk("rst_sp", 32'(sp), 32'hFF);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h00);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h00);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    op(OP_PUSH, 8'h3C);
    chk("push_busy_cycles", last_busy, 1);
    chk("push_sp", 32'(sp), 32'hFE);

    do_reset();
    op(OP_PUSH, 8'h11);
    op(OP_PUSH, 8'h22);
    op(OP_POP, 8'h00);
    chk("pop_rsp_latency", first_cyc - acc_cyc, 2);
    op(OP_POP, 8'h00);
    chk("pop_pop_sp", 32'(sp), 32'hFF);

    do_reset();
    for (int i = 0; i < 80; i++) op(OP_PUSH, 8'($urandom));
    chk("full_sp", 32'(sp), 32'hAF);
    chk("full_ovf_before", 32'(ovf), 32'd0);
    op(OP_PUSH, 8'hEE);
    chk("overflow_ovf", 32'(ovf), 32'd1);
    chk("overflow_sp", 32'(sp), 32'hAF);
    op(OP_LOAD, 8'hFF);
    chk("load_clears_ovf", 32'(ovf), 32'd0);

    do_reset();
    op(OP_POP, 8'h00);
    chk("udf_rsp_latency", first_cyc - acc_cyc, 0);
    chk("udf_flag", 32'(udf), 32'd1);
    chk("udf_sp", 32'(sp), 32'hFF);

    do_reset();
    op(OP_PUSH, 8'h5A);
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b0;
    do_op(OP_PEEK, 8'h00);
    r = 0;
    @(negedge clk);
    while (!bus.rsp_valid && r < 20) begin @(negedge clk); r++; end
    for (int i = 0; i < 3; i++) begin
      chk("peek_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("peek_hold_data", 32'(bus.rsp_data), 32'h5A);
      chk("peek_hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("peek_sp", 32'(sp), 32'hFE);

    do_reset();
    op(OP_PUSH, 8'h77);
    do_op(OP_POP, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rsp_before = n_rsp;
    rst_n = 1'b0;
    #1;
    chk("midrst_sp", 32'(sp), 32'hFF);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'h00);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_response", n_rsp, rsp_before);
    chk("midrst_sp_after", 32'(sp), 32'hFF);

    rand_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      v = 8'($urandom);
      if (r < 4) op(OP_PUSH, v);
      else if (r < 7) op(OP_POP, v);
      else if (r < 9) op(OP_PEEK, v);
      else op(OP_LOAD, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hAD, 8'hFF)) : SP_TOP);
    end
    repeat (4) @(negedge clk);
    chk("wrq_drained", wrq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
